// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: 68030 bus request/grant/acknowledge handshake for the DMA engine.
// Decides from FIFO state when the engine needs the bus, acquires it, hands it to the
// CPU bus-master state machine via BGRANT_, bounds the tenure and returns the bus.
module cpu_bus_arbiter #(
   parameter int MAX_BURST   = 8,    // bus cycles per tenure, 1..255
   parameter int HOLDOFF     = 2,    // idle clocks after release, 0..15
   parameter int GNT_TIMEOUT = 255   // clocks to wait for BG_, 1..255
) (
   input  logic SCLK,
   input  logic RST_,
   input  logic DMAENA,
   input  logic DMADIR,
   input  logic FIFOFULL,
   input  logic FIFOEMPTY,
   input  logic FLUSHFIFO,
   input  logic LASTWORD,
   input  logic BG_,
   input  logic AS_,
   input  logic DSACK0_,
   input  logic DSACK1_,
   input  logic STERM_,
   input  logic BGACK_IN_,
   input  logic CYCLEDONE,
   input  logic CYC_ACTIVE,
   output logic BR_,
   output logic BGACK_,
   output logic BGRANT_,
   output logic GNT_TO
);

   typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_e;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
   localparam logic [7:0] WAIT_LAST  = 8'(GNT_TIMEOUT - 1);
   localparam logic [3:0] HOLD_INIT  = 4'(HOLDOFF);

   state_e     state_q, state_d;
   logic       br_q, br_d;
   logic       bgack_q, bgack_d;
   logic       bgrant_q, bgrant_d;
   logic       gnt_to_q, gnt_to_d;
   logic [7:0] wait_q, wait_d;
   logic [7:0] burst_q, burst_d;
   logic [3:0] hold_q, hold_d;

   logic need, busfree, release_own;

   // Memory->SCSI needs the bus while the FIFO has room and words remain;
   // SCSI->memory needs it when full or when a partial FIFO must be flushed.
   assign need = DMAENA & (DMADIR ? (~FIFOFULL & ~LASTWORD)
                                  : (FIFOFULL | (FLUSHFIFO & ~FIFOEMPTY)));

   // The bus is ours only once granted and every other master's strobes are idle.
   assign busfree = ~BG_ & AS_ & DSACK0_ & DSACK1_ & STERM_ & BGACK_IN_;

   // Release only at a cycle boundary: either the finishing CYCLEDONE or no cycle in flight.
   assign release_own = (CYCLEDONE & (burst_q == BURST_LAST))
                      | (CYCLEDONE & ~need)
                      | (~need & ~CYC_ACTIVE)
                      | (~DMAENA & ~CYC_ACTIVE);

   // Next-state and registered-output decisions.
   always_comb begin
      state_d  = state_q;
      br_d     = br_q;
      bgack_d  = bgack_q;
      bgrant_d = bgrant_q;
      gnt_to_d = 1'b0;
      wait_d   = wait_q;
      burst_d  = burst_q;
      hold_d   = hold_q;
      case (state_q)
         IDLE: begin
            if (hold_q != 4'd0) hold_d = hold_q - 4'd1;
            // The clock leaving REL already counts as the first idle clock, so a
            // request may be decided while the counter is on its last step.
            if (need && (hold_q <= 4'd1)) begin
               state_d = REQ;
               br_d    = 1'b0;
               wait_d  = 8'd0;
               hold_d  = 4'd0;
            end
         end
         REQ: begin
            if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
            if (busfree) begin
               state_d  = OWN;
               br_d     = 1'b1;
               bgack_d  = 1'b0;
               bgrant_d = 1'b0;
               burst_d  = 8'd0;
            end else if (!need) begin
               state_d = IDLE;
               br_d    = 1'b1;
            end else if (wait_q == WAIT_LAST) begin
               state_d  = IDLE;
               br_d     = 1'b1;
               gnt_to_d = 1'b1;
            end
         end
         OWN: begin
            if (CYCLEDONE && (burst_q != 8'hFF)) burst_d = burst_q + 8'd1;
            if (release_own) begin
               state_d  = REL;
               bgrant_d = 1'b1;
            end
         end
         REL: begin
            state_d = IDLE;
            bgack_d = 1'b1;
            hold_d  = HOLD_INIT;
            burst_d = 8'd0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, asynchronously reset to the bus-released state.
   always_ff @(posedge SCLK or negedge RST_) begin
      if (!RST_) begin
         state_q  <= IDLE;
         br_q     <= 1'b1;
         bgack_q  <= 1'b1;
         bgrant_q <= 1'b1;
         gnt_to_q <= 1'b0;
         wait_q   <= 8'd0;
         burst_q  <= 8'd0;
         hold_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         br_q     <= br_d;
         bgack_q  <= bgack_d;
         bgrant_q <= bgrant_d;
         gnt_to_q <= gnt_to_d;
         wait_q   <= wait_d;
         burst_q  <= burst_d;
         hold_q   <= hold_d;
      end
   end

   assign BR_     = br_q;
   assign BGACK_  = bgack_q;
   assign BGRANT_ = bgrant_q;
   assign GNT_TO  = gnt_to_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: per-cycle comparison against a bench-side
// behavioural model plus hand-computed literal expectations for each scenario.
module tb_cpu_bus_arbiter;

   localparam int MAX_BURST   = 8;
   localparam int HOLDOFF     = 2;
   localparam int GNT_TIMEOUT = 255;

   logic SCLK = 1'b0;
   logic RST_ = 1'b0;
   logic DMAENA = 1'b0, DMADIR = 1'b0, FIFOFULL = 1'b0, FIFOEMPTY = 1'b1;
   logic FLUSHFIFO = 1'b0, LASTWORD = 1'b0;
   logic BG_ = 1'b1, AS_ = 1'b1, DSACK0_ = 1'b1, DSACK1_ = 1'b1, STERM_ = 1'b1;
   logic BGACK_IN_ = 1'b1, CYCLEDONE = 1'b0, CYC_ACTIVE = 1'b0;
   logic BR_, BGACK_, BGRANT_, GNT_TO;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_bus_arbiter #(
      .MAX_BURST(MAX_BURST), .HOLDOFF(HOLDOFF), .GNT_TIMEOUT(GNT_TIMEOUT)
   ) dut (
      .SCLK(SCLK), .RST_(RST_), .DMAENA(DMAENA), .DMADIR(DMADIR),
      .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY), .FLUSHFIFO(FLUSHFIFO),
      .LASTWORD(LASTWORD), .BG_(BG_), .AS_(AS_), .DSACK0_(DSACK0_),
      .DSACK1_(DSACK1_), .STERM_(STERM_), .BGACK_IN_(BGACK_IN_),
      .CYCLEDONE(CYCLEDONE), .CYC_ACTIVE(CYC_ACTIVE), .BR_(BR_),
      .BGACK_(BGACK_), .BGRANT_(BGRANT_), .GNT_TO(GNT_TO)
   );

   always #5 SCLK = ~SCLK;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge SCLK);
   endtask

   // ---------------- behavioural model ----------------
   // The phase of a tenure is read straight off the expected bus outputs:
   // BR_ low = requesting, BGRANT_ low = owning, BGACK_ low alone = releasing.
   logic m_br = 1'b1, m_bgack = 1'b1, m_bgrant = 1'b1, m_to = 1'b0;
   int   m_req = 0, m_done = 0, m_quiet = 100;
   localparam int MIN_QUIET = (HOLDOFF > 1) ? HOLDOFF : 1;

   wire m_need = DMAENA && (DMADIR ? (!FIFOFULL && !LASTWORD)
                                   : (FIFOFULL || (FLUSHFIFO && !FIFOEMPTY)));
   wire m_busfree = !BG_ && AS_ && DSACK0_ && DSACK1_ && STERM_ && BGACK_IN_;

   // Model advances on each rising edge from the inputs it sees there.
   always @(posedge SCLK or negedge RST_) begin
      if (!RST_) begin
         m_br <= 1'b1; m_bgack <= 1'b1; m_bgrant <= 1'b1; m_to <= 1'b0;
         m_req <= 0; m_done <= 0; m_quiet <= 100;
      end else begin
         m_to <= 1'b0;
         if (!m_br) begin
            m_req <= m_req + 1;
            if (m_busfree) begin
               m_br <= 1'b1; m_bgack <= 1'b0; m_bgrant <= 1'b0; m_done <= 0;
            end else if (!m_need) begin
               m_br <= 1'b1; m_quiet <= 100;
            end else if (m_req + 1 == GNT_TIMEOUT) begin
               m_br <= 1'b1; m_to <= 1'b1; m_quiet <= 100;
            end
         end else if (!m_bgrant) begin
            if (CYCLEDONE) m_done <= m_done + 1;
            if ((CYCLEDONE && (m_done + 1 == MAX_BURST || !m_need)) ||
                (!m_need && !CYC_ACTIVE) || (!DMAENA && !CYC_ACTIVE))
               m_bgrant <= 1'b1;
         end else if (!m_bgack) begin
            m_bgack <= 1'b1; m_quiet <= 0;
         end else begin
            m_quiet <= (m_quiet < 100) ? m_quiet + 1 : 100;
            if (m_need && (m_quiet + 1 >= MIN_QUIET)) begin
               m_br <= 1'b0; m_req <= 0;
            end
         end
      end
   end

   // Every falling edge: DUT outputs against the model, plus BR_/BGACK_ exclusivity.
   always @(negedge SCLK) begin
      chk("BR_", BR_, m_br);
      chk("BGACK_", BGACK_, m_bgack);
      chk("BGRANT_", BGRANT_, m_bgrant);
      chk("GNT_TO", GNT_TO, m_to);
      chk("br_bgack_both_low", !BR_ && !BGACK_, 1'b0);
   end

   // Overall time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int n;
      // reset state
      repeat (3) tick();
      chk("rst_br", BR_, 1'b1);
      chk("rst_bgack", BGACK_, 1'b1);
      chk("rst_bgrant", BGRANT_, 1'b1);
      chk("rst_gnt_to", GNT_TO, 1'b0);
      RST_ = 1'b1;
      tick();

      // 1: drain direction, FIFO full, BG_ arrives 3 clocks after BR_
      DMAENA = 1'b1; DMADIR = 1'b0; FIFOFULL = 1'b1;
      tick();
      chk("t1_br_low", BR_, 1'b0);
      repeat (2) tick();
      chk("t1_no_grant_yet", BGACK_, 1'b1);
      BG_ = 1'b0;
      tick();
      chk("t1_bgack_low", BGACK_, 1'b0);
      chk("t1_bgrant_low", BGRANT_, 1'b0);
      chk("t1_br_high", BR_, 1'b1);
      BG_ = 1'b1;

      // 2: eight bus cycles end the tenure, then holdoff before re-request
      for (int i = 0; i < 8; i++) begin
         CYC_ACTIVE = 1'b1;
         tick();
         CYCLEDONE = 1'b1;
         tick();
         chk("t2_bgrant_after_cycle", BGRANT_, (i == 7) ? 1'b1 : 1'b0);
         CYCLEDONE = 1'b0; CYC_ACTIVE = 1'b0;
      end
      chk("t2_bgack_still_low", BGACK_, 1'b0);
      tick();
      chk("t2_bgack_high", BGACK_, 1'b1);
      n = 0;
      while (BR_ && n < 20) begin tick(); n++; end
      chk_int("t2_holdoff_clocks", n, 2);

      // 3: grant present but another master's cycle still on the bus
      BG_ = 1'b0; AS_ = 1'b0; DSACK0_ = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_wait_as", BGACK_, 1'b1);
      end
      AS_ = 1'b1;
      tick();
      chk("t3_wait_dsack", BGACK_, 1'b1);
      DSACK0_ = 1'b1; STERM_ = 1'b0;
      tick();
      chk("t3_wait_sterm", BGACK_, 1'b1);
      STERM_ = 1'b1;
      tick();
      chk("t3_bgack_low", BGACK_, 1'b0);
      BG_ = 1'b1;

      // 5: DMAENA dropped mid-cycle; grant held until the cycle completes
      CYC_ACTIVE = 1'b1;
      tick();
      DMAENA = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_bgrant_held", BGRANT_, 1'b0);
      end
      CYCLEDONE = 1'b1;
      tick();
      chk("t5_bgrant_high", BGRANT_, 1'b1);
      chk("t5_bgack_low", BGACK_, 1'b0);
      CYCLEDONE = 1'b0; CYC_ACTIVE = 1'b0;
      tick();
      chk("t5_bgack_high", BGACK_, 1'b1);

      // 4: BG_ never arrives -> timeout after GNT_TIMEOUT clocks, then re-request
      DMAENA = 1'b1;
      n = 0;
      while (BR_ && n < 10) begin tick(); n++; end
      chk("t4_br_low", BR_, 1'b0);
      n = 0;
      while (!BR_ && n < 400) begin n++; tick(); end
      chk_int("t4_br_low_clocks", n, 255);
      chk("t4_gnt_to_pulse", GNT_TO, 1'b1);
      tick();
      chk("t4_gnt_to_clear", GNT_TO, 1'b0);
      chk("t4_rerequest", BR_, 1'b0);

      // withdrawal and the other NEED terms
      FIFOFULL = 1'b0;
      tick();
      chk("need_drop_withdraw", BR_, 1'b1);
      DMADIR = 1'b1;
      tick();
      chk("fill_need_request", BR_, 1'b0);
      LASTWORD = 1'b1;
      tick();
      chk("lastword_withdraw", BR_, 1'b1);
      DMADIR = 1'b0; LASTWORD = 1'b0; FLUSHFIFO = 1'b1; FIFOEMPTY = 1'b0;
      tick();
      chk("flush_need_request", BR_, 1'b0);
      BG_ = 1'b0;
      tick();
      chk("t6_owned", BGACK_, 1'b0);

      // 6: asynchronous reset while owning the bus
      @(posedge SCLK);
      #2 RST_ = 1'b0;
      #1;
      chk("t6_async_br", BR_, 1'b1);
      chk("t6_async_bgack", BGACK_, 1'b1);
      chk("t6_async_bgrant", BGRANT_, 1'b1);
      tick();
      BG_ = 1'b1; DMAENA = 1'b0;
      RST_ = 1'b1;
      repeat (3) tick();
      chk("t6_idle_after_reset", BR_, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
